// File: rtl/wb_forward_unit_pkg.sv
// Shared definitions for the writeback pipeline and forwarding unit:
// entry layout widths and the forwarding-source classification.
package wb_forward_unit_pkg;

  localparam int MAX_DEPTH = 4;
  localparam int CTRL_BITS = 3;  // valid, wrtEn, isLoad

  typedef enum logic [1:0] {
    SRC_RF     = 2'd0,
    SRC_DATA   = 2'd1,
    SRC_MEM    = 2'd2,
    SRC_HAZARD = 2'd3
  } fwd_src_e;

  function automatic int entry_width(input int dbits, input int ribw);
    return CTRL_BITS + ribw + dbits;
  endfunction

  // Where a matching entry's value comes from, given its stage and the load stage.
  function automatic fwd_src_e match_source(input logic is_load, input int stage,
                                            input int load_stage);
    fwd_src_e src;
    if (!is_load) begin
      src = SRC_DATA;
    end else if (stage < load_stage) begin
      src = SRC_HAZARD;
    end else if (stage == load_stage) begin
      src = SRC_MEM;
    end else begin
      src = SRC_DATA;
    end
    return src;
  endfunction

endpackage

// File: rtl/wb_forward_unit_pipe_entry_reg.sv
// One in-flight result stage: packed entry register with bubble insertion and,
// when it follows the load stage, capture of memory read data for loads.
module pipe_entry_reg
  import wb_forward_unit_pkg::*;
#(
  parameter int DBITS   = 32,
  parameter int RIBW    = 4,
  parameter bit CAPTURE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bubble,
  input  logic             in_valid,
  input  logic             in_wrtEn,
  input  logic             in_isLoad,
  input  logic [RIBW-1:0]  in_dr,
  input  logic [DBITS-1:0] in_data,
  input  logic [DBITS-1:0] mem_dOut,
  output logic             q_valid,
  output logic             q_wrtEn,
  output logic             q_isLoad,
  output logic [RIBW-1:0]  q_dr,
  output logic [DBITS-1:0] q_data
);

  localparam int ENTRY_W = entry_width(DBITS, RIBW);

  logic [DBITS-1:0]   data_next;
  logic [ENTRY_W-1:0] entry_next;
  logic [ENTRY_W-1:0] entry_q;

  // A load leaving the load stage takes the memory read data as its result.
  always_comb begin
    if (CAPTURE && in_isLoad) begin
      data_next = mem_dOut;
    end else begin
      data_next = in_data;
    end
  end

  always_comb begin
    entry_next = {in_valid & ~bubble, in_wrtEn, in_isLoad, in_dr, data_next};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_next;
    end
  end

  assign {q_valid, q_wrtEn, q_isLoad, q_dr, q_data} = entry_q;

endmodule

// File: rtl/wb_forward_unit.sv
// Writeback pipeline of DEPTH result stages with youngest-match operand
// forwarding, load-use interlock, issue squash on flush and register-file retire.
module wb_forward_unit
  import wb_forward_unit_pkg::*;
#(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DEPTH               = 1,
  parameter int LOAD_STAGE          = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic                           issue_wrtEn,
  input  logic                           issue_isLoad,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] issue_dr,
  input  logic [DBITS-1:0]               issue_data,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] sr1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] sr2,
  input  logic                           use_sr1,
  input  logic                           use_sr2,
  input  logic [DBITS-1:0]               sr1_rf,
  input  logic [DBITS-1:0]               sr2_rf,
  input  logic [DBITS-1:0]               mem_dOut,
  input  logic                           flush,
  output logic [DBITS-1:0]               fwd1,
  output logic [DBITS-1:0]               fwd2,
  output logic                           stall,
  output logic                           wb_wrtEn,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wb_dr,
  output logic [DBITS-1:0]               wb_data
);

  localparam int RIBW = REG_INDEX_BIT_WIDTH;

  logic [DEPTH:1]   st_valid;
  logic [DEPTH:1]   st_wrtEn;
  logic [DEPTH:1]   st_isLoad;
  logic [RIBW-1:0]  st_dr   [1:DEPTH];
  logic [DBITS-1:0] st_data [1:DEPTH];

  // Stage 1 takes the issuing instruction; later stages shift from their predecessor.
  for (genvar g = 1; g <= DEPTH; g++) begin : g_stage
    if (g == 1) begin : g_head
      pipe_entry_reg #(
        .DBITS  (DBITS),
        .RIBW   (RIBW),
        .CAPTURE(1'b0)
      ) u_entry (
        .clk      (clk),
        .reset    (reset),
        .bubble   (stall | flush),
        .in_valid (issue_valid),
        .in_wrtEn (issue_wrtEn),
        .in_isLoad(issue_isLoad),
        .in_dr    (issue_dr),
        .in_data  (issue_data),
        .mem_dOut (mem_dOut),
        .q_valid  (st_valid[g]),
        .q_wrtEn  (st_wrtEn[g]),
        .q_isLoad (st_isLoad[g]),
        .q_dr     (st_dr[g]),
        .q_data   (st_data[g])
      );
    end else begin : g_tail
      pipe_entry_reg #(
        .DBITS  (DBITS),
        .RIBW   (RIBW),
        .CAPTURE((g - 1) == LOAD_STAGE)
      ) u_entry (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .in_valid (st_valid[g-1]),
        .in_wrtEn (st_wrtEn[g-1]),
        .in_isLoad(st_isLoad[g-1]),
        .in_dr    (st_dr[g-1]),
        .in_data  (st_data[g-1]),
        .mem_dOut (mem_dOut),
        .q_valid  (st_valid[g]),
        .q_wrtEn  (st_wrtEn[g]),
        .q_isLoad (st_isLoad[g]),
        .q_dr     (st_dr[g]),
        .q_data   (st_data[g])
      );
    end
  end

  // One priority chain per source operand; scanning oldest to youngest lets the youngest hit win.
  for (genvar s = 0; s < 2; s++) begin : g_fwd
    logic [RIBW-1:0]  idx;
    logic             use_src;
    logic [DBITS-1:0] rf;
    logic [DBITS-1:0] value;
    logic             hazard;
    logic             hit;
    fwd_src_e         kind;

    assign idx     = (s == 0) ? sr1 : sr2;
    assign use_src = (s == 0) ? use_sr1 : use_sr2;
    assign rf      = (s == 0) ? sr1_rf : sr2_rf;

    always_comb begin
      value  = rf;
      hazard = 1'b0;
      hit    = 1'b0;
      kind   = SRC_RF;
      for (int i = DEPTH; i >= 1; i--) begin
        hit    = st_valid[i] & st_wrtEn[i] & use_src & (st_dr[i] == idx);
        kind   = match_source(st_isLoad[i], i, LOAD_STAGE);
        value  = hit ? ((kind == SRC_MEM) ? mem_dOut : st_data[i]) : value;
        hazard = hit ? (kind == SRC_HAZARD) : hazard;
      end
    end
  end

  assign fwd1  = g_fwd[0].value;
  assign fwd2  = g_fwd[1].value;
  assign stall = issue_valid & ~flush & (g_fwd[0].hazard | g_fwd[1].hazard);

  // Retire from the oldest stage; a load still in its load stage writes the live memory data.
  always_comb begin
    wb_wrtEn = st_valid[DEPTH] & st_wrtEn[DEPTH];
    wb_dr    = st_dr[DEPTH];
    if (st_isLoad[DEPTH] && (LOAD_STAGE == DEPTH)) begin
      wb_data = mem_dOut;
    end else begin
      wb_data = st_data[DEPTH];
    end
  end

endmodule

// File: tb/tb_wb_forward_unit.sv
// Bench for wb_forward_unit: three configurations share one stimulus stream and
// are compared each cycle against a queue-style model of the in-flight results.
module tb_wb_forward_unit;

  localparam int DB = 32;
  localparam int RB = 4;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_wrtEn, issue_isLoad, flush, use_sr1, use_sr2;
  logic [RB-1:0] issue_dr, sr1, sr2;
  logic [DB-1:0] issue_data, sr1_rf, sr2_rf, mem_dOut;

  logic [DB-1:0] fwd1_o    [NI];
  logic [DB-1:0] fwd2_o    [NI];
  logic [DB-1:0] wb_data_o [NI];
  logic [RB-1:0] wb_dr_o   [NI];
  logic [NI-1:0] stall_o;
  logic [NI-1:0] wb_wrtEn_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          valid;
    logic          wrtEn;
    logic          isLoad;
    logic [RB-1:0] dr;
    logic [DB-1:0] data;
  } ent_t;

  ent_t pipe [NI][4];  // index 0 is the youngest stage

  always #5 clk = ~clk;

  wb_forward_unit #(.DBITS(DB), .REG_INDEX_BIT_WIDTH(RB), .DEPTH(1), .LOAD_STAGE(1)) u_d1 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wrtEn(issue_wrtEn),
    .issue_isLoad(issue_isLoad), .issue_dr(issue_dr), .issue_data(issue_data),
    .sr1(sr1), .sr2(sr2), .use_sr1(use_sr1), .use_sr2(use_sr2), .sr1_rf(sr1_rf),
    .sr2_rf(sr2_rf), .mem_dOut(mem_dOut), .flush(flush), .fwd1(fwd1_o[0]), .fwd2(fwd2_o[0]),
    .stall(stall_o[0]), .wb_wrtEn(wb_wrtEn_o[0]), .wb_dr(wb_dr_o[0]), .wb_data(wb_data_o[0]));

  wb_forward_unit #(.DBITS(DB), .REG_INDEX_BIT_WIDTH(RB), .DEPTH(2), .LOAD_STAGE(2)) u_d2 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wrtEn(issue_wrtEn),
    .issue_isLoad(issue_isLoad), .issue_dr(issue_dr), .issue_data(issue_data),
    .sr1(sr1), .sr2(sr2), .use_sr1(use_sr1), .use_sr2(use_sr2), .sr1_rf(sr1_rf),
    .sr2_rf(sr2_rf), .mem_dOut(mem_dOut), .flush(flush), .fwd1(fwd1_o[1]), .fwd2(fwd2_o[1]),
    .stall(stall_o[1]), .wb_wrtEn(wb_wrtEn_o[1]), .wb_dr(wb_dr_o[1]), .wb_data(wb_data_o[1]));

  wb_forward_unit #(.DBITS(DB), .REG_INDEX_BIT_WIDTH(RB), .DEPTH(4), .LOAD_STAGE(2)) u_d4 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wrtEn(issue_wrtEn),
    .issue_isLoad(issue_isLoad), .issue_dr(issue_dr), .issue_data(issue_data),
    .sr1(sr1), .sr2(sr2), .use_sr1(use_sr1), .use_sr2(use_sr2), .sr1_rf(sr1_rf),
    .sr2_rf(sr2_rf), .mem_dOut(mem_dOut), .flush(flush), .fwd1(fwd1_o[2]), .fwd2(fwd2_o[2]),
    .stall(stall_o[2]), .wb_wrtEn(wb_wrtEn_o[2]), .wb_dr(wb_dr_o[2]), .wb_data(wb_data_o[2]));

  function automatic int depth_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int ls_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++)
      for (int j = 0; j < 4; j++)
        pipe[k][j] = '0;
  endtask

  // Youngest pending writer of s decides the operand; loads before their data stage are hazards.
  task automatic resolve(input int k, input logic [RB-1:0] s, input logic use_s,
                         input logic [DB-1:0] rf, output logic [DB-1:0] v, output logic hz);
    bit found;
    v = rf;
    hz = 1'b0;
    found = 1'b0;
    for (int j = 0; j < depth_of(k); j++) begin
      if (!found && use_s && pipe[k][j].valid && pipe[k][j].wrtEn && pipe[k][j].dr == s) begin
        found = 1'b1;
        if (!pipe[k][j].isLoad)        v  = pipe[k][j].data;
        else if (j + 1 < ls_of(k))     hz = 1'b1;
        else if (j + 1 == ls_of(k))    v  = mem_dOut;
        else                           v  = pipe[k][j].data;
      end
    end
  endtask

  task automatic model_step();
    logic [DB-1:0] v;
    logic h1, h2, stl;
    for (int k = 0; k < NI; k++) begin
      resolve(k, sr1, use_sr1, sr1_rf, v, h1);
      resolve(k, sr2, use_sr2, sr2_rf, v, h2);
      stl = issue_valid & ~flush & (h1 | h2);
      for (int j = depth_of(k) - 1; j >= 1; j--) begin
        pipe[k][j] = pipe[k][j-1];
        if (j == ls_of(k) && pipe[k][j].isLoad) pipe[k][j].data = mem_dOut;
      end
      pipe[k][0] = '0;
      if (issue_valid && !stl && !flush) begin
        pipe[k][0].valid  = 1'b1;
        pipe[k][0].wrtEn  = issue_wrtEn;
        pipe[k][0].isLoad = issue_isLoad;
        pipe[k][0].dr     = issue_dr;
        pipe[k][0].data   = issue_isLoad ? '0 : issue_data;
      end
    end
  endtask

  task automatic check_all();
    logic [DB-1:0] v1, v2;
    logic h1, h2;
    ent_t last;
    for (int k = 0; k < NI; k++) begin
      resolve(k, sr1, use_sr1, sr1_rf, v1, h1);
      resolve(k, sr2, use_sr2, sr2_rf, v2, h2);
      check($sformatf("stall[%0d]", k), DB'(stall_o[k]), DB'(issue_valid & ~flush & (h1 | h2)));
      if (!h1) check($sformatf("fwd1[%0d]", k), fwd1_o[k], v1);
      if (!h2) check($sformatf("fwd2[%0d]", k), fwd2_o[k], v2);
      last = pipe[k][depth_of(k)-1];
      check($sformatf("wb_wrtEn[%0d]", k), DB'(wb_wrtEn_o[k]), DB'(last.valid & last.wrtEn));
      if (last.valid && last.wrtEn) begin
        check($sformatf("wb_dr[%0d]", k), DB'(wb_dr_o[k]), DB'(last.dr));
        check($sformatf("wb_data[%0d]", k), wb_data_o[k],
              (last.isLoad && ls_of(k) == depth_of(k)) ? mem_dOut : last.data);
      end
    end
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_wrtEn = 1'b0; issue_isLoad = 1'b0; flush = 1'b0;
    use_sr1 = 1'b0; use_sr2 = 1'b0; issue_dr = '0; sr1 = '0; sr2 = '0;
    issue_data = '0; sr1_rf = '0; sr2_rf = '0; mem_dOut = '0;
  endtask

  task automatic issue(input logic wr, input logic ld, input logic [RB-1:0] dr,
                       input logic [DB-1:0] data);
    drive_idle();
    issue_valid = 1'b1; issue_wrtEn = wr; issue_isLoad = ld; issue_dr = dr; issue_data = data;
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    drive_idle();
    repeat (5) begin sample(); advance(); end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    model_reset();
    #12 reset = 1'b1;
    advance();
    sample();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_wrtEn[%0d]", k), DB'(wb_wrtEn_o[k]), '0);
      check($sformatf("rst_stall[%0d]", k), DB'(stall_o[k]), '0);
    end
    advance();

    // DEPTH=1 back-to-back forward of an ALU result
    issue(1'b1, 1'b0, 4'd3, 32'h0000_0010); sample(); advance();
    issue(1'b0, 1'b0, 4'd0, 32'h0); sr1 = 4'd3; use_sr1 = 1'b1; sr1_rf = 32'h0;
    sample();
    check("t2_fwd1", fwd1_o[0], 32'h0000_0010);
    check("t2_wb_dr", DB'(wb_dr_o[0]), 32'd3);
    check("t2_wb_wrtEn", DB'(wb_wrtEn_o[0]), 32'd1);
    advance();

    // Load-use: one stall cycle, then memory data forwarded
    drain();
    issue(1'b1, 1'b1, 4'd5, 32'h0); sample(); advance();
    issue(1'b0, 1'b0, 4'd0, 32'h0); sr1 = 4'd5; use_sr1 = 1'b1; mem_dOut = 32'hDEAD_BEEF;
    sample(); check("t3_stall_on", DB'(stall_o[1]), 32'd1); advance();
    sample(); check("t3_stall_off", DB'(stall_o[1]), 32'd0);
    check("t3_fwd1", fwd1_o[1], 32'hDEAD_BEEF); advance();

    // Two writers of r4 in flight: youngest forwards, oldest retires
    drain();
    issue(1'b1, 1'b0, 4'd4, 32'd1); sample(); advance();
    issue(1'b1, 1'b0, 4'd4, 32'd2); sample(); advance();
    issue(1'b0, 1'b0, 4'd0, 32'h0); sr1 = 4'd4; use_sr1 = 1'b1; sr1_rf = 32'hFFFF_0000;
    sample();
    check("t4_fwd1", fwd1_o[1], 32'd2);
    check("t4_wb_data", wb_data_o[1], 32'd1);
    advance();

    // Flush beats a load-use hazard and squashes the issue
    drain();
    issue(1'b1, 1'b1, 4'd5, 32'h0); sample(); advance();
    issue(1'b1, 1'b0, 4'd6, 32'h66); sr1 = 4'd5; use_sr1 = 1'b1; flush = 1'b1;
    sample(); check("t5_stall", DB'(stall_o[1]), 32'd0); advance();
    drive_idle();
    sample(); check("t5_bubble_d1", DB'(wb_wrtEn_o[0]), 32'd0); advance();
    sample(); check("t5_bubble_d2", DB'(wb_wrtEn_o[1]), 32'd0); advance();

    // Unused source never interlocks
    drain();
    issue(1'b1, 1'b1, 4'd5, 32'h0); sample(); advance();
    issue(1'b0, 1'b0, 4'd0, 32'h0); sr2 = 4'd5; use_sr2 = 1'b0; sr2_rf = 32'h0000_1234;
    sample();
    check("t6_stall", DB'(stall_o[1]), 32'd0);
    check("t6_fwd2", fwd2_o[1], 32'h0000_1234);
    advance();

    // Mid-stream reset discards in-flight entries
    drain();
    issue(1'b1, 1'b0, 4'd7, 32'h77); sample(); advance();
    issue(1'b1, 1'b0, 4'd8, 32'h88); sample(); advance();
    drive_idle();
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      check($sformatf("t1_wrtEn[%0d]", k), DB'(wb_wrtEn_o[k]), '0);
    model_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    advance();
    issue(1'b0, 1'b0, 4'd0, 32'h0); sr1 = 4'd7; use_sr1 = 1'b1; sr1_rf = 32'h55;
    sample();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("t1_fwd1[%0d]", k), fwd1_o[k], 32'h55);
      check($sformatf("t1_stall[%0d]", k), DB'(stall_o[k]), '0);
    end
    advance();

    // Randomized traffic over a small register window to provoke matches and hazards
    for (int c = 0; c < 800; c++) begin
      issue_valid  = ($urandom_range(0, 3) != 0);
      issue_wrtEn  = ($urandom_range(0, 4) != 0);
      issue_isLoad = ($urandom_range(0, 2) == 0);
      issue_dr     = RB'($urandom_range(0, 3));
      issue_data   = $urandom;
      sr1          = RB'($urandom_range(0, 3));
      sr2          = RB'($urandom_range(0, 3));
      use_sr1      = ($urandom_range(0, 3) != 0);
      use_sr2      = ($urandom_range(0, 3) != 0);
      sr1_rf       = $urandom;
      sr2_rf       = $urandom;
      mem_dOut     = $urandom;
      flush        = ($urandom_range(0, 7) == 0);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
